// File: rtl/scmp_useq_pkg.sv
// rtl/scmp_useq_pkg.sv - shared types and constants for the SC/MP microcode sequencer
package scmp_useq_pak;

    localparam int DEF_PC_W = 8;
    localparam logic [7:0] DEF_IRQ_VEC = 8'hF0;

    typedef logic [DEF_PC_W-1:0] MPC_t;

    // Which source feeds the next micro-PC, in priority order.
    typedef enum logic [2:0] {
        SEL_HOLD,
        SEL_DECODE,
        SEL_RET,
        SEL_CJMP,
        SEL_FETCH,
        SEL_IRQ,
        SEL_REL
    } SEQ_SEL_t;

endpackage

// File: rtl/scmp_useq_stack.sv
// rtl/scmp_useq_stack.sv - return-address LIFO with combined push/pop replace
module scmp_useq_stack #(
    parameter int PC_W    = 8,
    parameter int STACK_D = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             push,
    input  logic                             pop,
    input  logic [PC_W-1:0]                  din,
    output logic [PC_W-1:0]                  dout,
    output logic [$clog2(STACK_D+1)-1:0]     sp,
    output logic                             full,
    output logic                             empty
);

    localparam int SP_W = $clog2(STACK_D+1);

    logic [PC_W-1:0] mem [STACK_D];
    logic            wr_en;
    logic [SP_W-1:0] wr_idx;
    logic [SP_W-1:0] sp_nxt;
    logic [SP_W-1:0] top_idx;

    assign full    = (sp == SP_W'(STACK_D));
    assign empty   = (sp == '0);
    assign top_idx = sp - SP_W'(1);

    always_comb begin
        dout = '0;
        for (int i = 0; i < STACK_D; i++) begin
            if (!empty && top_idx == SP_W'(i)) dout = mem[i];
        end
    end

    // Push+pop overwrites the top in place; on an empty stack it degenerates to a plain push.
    always_comb begin
        wr_en  = 1'b0;
        wr_idx = sp;
        sp_nxt = sp;
        if (push && pop) begin
            wr_en  = 1'b1;
            wr_idx = empty ? '0 : top_idx;
            sp_nxt = empty ? SP_W'(1) : sp;
        end else if (push && !full) begin
            wr_en  = 1'b1;
            wr_idx = sp;
            sp_nxt = sp + SP_W'(1);
        end else if (pop && !empty) begin
            sp_nxt = top_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp <= '0;
            for (int i = 0; i < STACK_D; i++) mem[i] <= '0;
        end else begin
            sp <= sp_nxt;
            for (int i = 0; i < STACK_D; i++) begin
                if (wr_en && wr_idx == SP_W'(i)) mem[i] <= din;
            end
        end
    end

endmodule

// File: rtl/scmp_useq.sv
// rtl/scmp_useq.sv - SC/MP microcode sequencer: next micro-PC, return stack, irq trap
module scmp_useq
    import scmp_useq_pak::*;
#(
    parameter int              PC_W    = 8,
    parameter int              COND_W  = 9,
    parameter int              STACK_D = 4,
    parameter logic [PC_W-1:0] IRQ_VEC = PC_W'(DEF_IRQ_VEC)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          stall,
    input  logic                          uw_decode,
    input  logic                          uw_ret,
    input  logic                          uw_call,
    input  logic                          uw_cond_jmp,
    input  logic [PC_W-1:0]               uw_nextpc,
    input  logic [COND_W-1:0]             uw_cond_mask,
    input  logic [COND_W-1:0]             uw_cond_xor,
    input  logic [COND_W-1:0]             cond_in,
    input  logic [PC_W-1:0]               op_pc,
    input  logic                          irq_req,
    output logic [PC_W-1:0]               mc_pc,
    output logic                          cond,
    output logic                          irq_ack,
    output logic [$clog2(STACK_D+1)-1:0]  sp,
    output logic                          err_ovf,
    output logic                          err_unf
);

    SEQ_SEL_t        sel;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] pc_nxt;
    logic [PC_W-1:0] stk_dout;
    logic            push;
    logic            pop;
    logic            stk_full;
    logic            stk_empty;

    assign cond   = |((cond_in ^ uw_cond_xor) & uw_cond_mask);
    assign pc_inc = mc_pc + PC_W'(1);

    // Interrupts are only taken at a fetch boundary so a macro-instruction is never split.
    always_comb begin
        sel = SEL_REL;
        if (stall)                     sel = SEL_HOLD;
        else if (uw_decode)            sel = SEL_DECODE;
        else if (uw_ret)               sel = SEL_RET;
        else if (uw_cond_jmp && cond)  sel = SEL_CJMP;
        else if (uw_nextpc == '0)      sel = irq_req ? SEL_IRQ : SEL_FETCH;
    end

    always_comb begin
        pc_nxt = mc_pc;
        case (sel)
            SEL_HOLD:   pc_nxt = mc_pc;
            SEL_DECODE: pc_nxt = op_pc;
            SEL_RET:    pc_nxt = stk_dout;
            SEL_CJMP:   pc_nxt = pc_inc;
            SEL_FETCH:  pc_nxt = '0;
            SEL_IRQ:    pc_nxt = IRQ_VEC;
            SEL_REL:    pc_nxt = mc_pc + uw_nextpc;
            default:    pc_nxt = mc_pc;
        endcase
    end

    assign push = uw_call && !stall;
    assign pop  = (sel == SEL_RET);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mc_pc   <= '0;
            irq_ack <= 1'b0;
            err_ovf <= 1'b0;
            err_unf <= 1'b0;
        end else begin
            mc_pc   <= pc_nxt;
            irq_ack <= (sel == SEL_IRQ);
            if (pop && stk_empty)          err_unf <= 1'b1;
            if (push && !pop && stk_full)  err_ovf <= 1'b1;
        end
    end

    scmp_useq_stack #(
        .PC_W    (PC_W),
        .STACK_D (STACK_D)
    ) u_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (pc_inc),
        .dout  (stk_dout),
        .sp    (sp),
        .full  (stk_full),
        .empty (stk_empty)
    );

endmodule
